// File: rtl/glitc_trigger_pkg.sv
// Shared types and helpers for the GLITC trigger threshold servo.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
// Contents: servo FSM state enum, default power-word width, threshold width,
// and saturating add/subtract helpers operating on 32-bit unsigned values.
package glitc_trigger_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_COUNT  = 2'd1,
        ST_EVAL   = 2'd2,
        ST_UPDATE = 2'd3
    } servo_state_t;

    localparam int POWERBITS_DEF = 12;
    localparam int THRESH_W_DEF  = POWERBITS_DEF + 2;

    // a + b, clamped to max_v
    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic [31:0] max_v);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum > {1'b0, max_v}) begin
            return max_v;
        end
        return sum[31:0];
    endfunction

    // a - b, clamped at zero
    function automatic logic [31:0] sat_sub(input logic [31:0] a,
                                            input logic [31:0] b);
        return (a < b) ? 32'd0 : (a - b);
    endfunction

endpackage

// File: rtl/glitc_sat_counter.sv
// Gated saturating event counter with synchronous clear.
// Latency: count reflects inc_i one clock later; clear takes effect on the next edge.
// Backpressure: none; holds at all-ones once saturated.
// Ports: clk_i/rst_n_i (sync active-low), clr_i (clear, wins over inc_i),
//        inc_i (count this cycle), cnt_o (current count).
module glitc_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/glitc_threshold_servo.sv
// Closed-loop power-threshold servo for one phi sector: counts triggers per gate and steps the threshold toward the goal rate.
// Latency: last gate sample -> threshold_o in 2 clocks (EVAL, UPDATE); 2 dead trigger cycles per gate.
// Backpressure: none; enable_i low idles the loop, load_i overrides the threshold at any time.
// Ports: clk_i, rst_n_i (sync active-low), trig_i, enable_i, load_i, threshold_init_i,
//        goal_i, deadband_i, step_i, period_i -> threshold_o, threshold_update_o, rate_o, rate_valid_o.
// Build option: define GLITC_THRESHOLD_SERVO_EDGE_EN to count only trig_i rising edges.
module glitc_threshold_servo
    import glitc_trigger_pkg::*;
#(
    parameter int POWERBITS      = POWERBITS_DEF,
    parameter int PERIODBITS     = 24,
    parameter int RATEBITS       = 16,
    parameter int THRESH_DEFAULT = 4095
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  trig_i,
    input  logic                  enable_i,
    input  logic                  load_i,
    input  logic [POWERBITS+1:0]  threshold_init_i,
    input  logic [RATEBITS-1:0]   goal_i,
    input  logic [RATEBITS-1:0]   deadband_i,
    input  logic [POWERBITS+1:0]  step_i,
    input  logic [PERIODBITS-1:0] period_i,
    output logic [POWERBITS+1:0]  threshold_o,
    output logic                  threshold_update_o,
    output logic [RATEBITS-1:0]   rate_o,
    output logic                  rate_valid_o
);

    localparam int          TW      = POWERBITS + 2;
    localparam logic [31:0] THR_MAX = 32'((64'd1 << TW) - 64'd1);

    servo_state_t          state_q;
    logic [PERIODBITS-1:0] period_q;
    logic [PERIODBITS-1:0] gate_cnt_q;
    logic [TW-1:0]         thr_q;
    logic [TW-1:0]         next_q;
    logic                  thr_upd_q;
    logic [RATEBITS-1:0]   rate_q;
    logic                  rate_vld_q;

    logic [RATEBITS-1:0]   cnt;
    logic                  start_gate;
    logic                  trig_hit;
    logic                  cnt_inc;
    logic [PERIODBITS-1:0] period_lat;
    logic [RATEBITS:0]     hi_lim;
    logic [RATEBITS:0]     lo_sum;
    logic [TW-1:0]         next_calc;

    // A new gate begins whenever the FSM will enter COUNT on this edge.
    always_comb begin
        start_gate = 1'b0;
        if (load_i) begin
            start_gate = enable_i;
        end else begin
            case (state_q)
                ST_IDLE, ST_UPDATE: start_gate = enable_i;
                default:            start_gate = 1'b0;
            endcase
        end
    end

`ifdef GLITC_THRESHOLD_SERVO_EDGE_EN
    // Previous-sample register is cleared at gate start so a gate opening
    // with trig_i already high still counts one edge.
    logic prev_trig_q;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            prev_trig_q <= 1'b0;
        end else if (start_gate) begin
            prev_trig_q <= 1'b0;
        end else begin
            prev_trig_q <= trig_i;
        end
    end

    assign trig_hit = trig_i & ~prev_trig_q;
`else
    assign trig_hit = trig_i;
`endif

    assign cnt_inc    = (state_q == ST_COUNT) && trig_hit;
    assign period_lat = (period_i == '0) ? PERIODBITS'(1) : period_i;

    glitc_sat_counter #(
        .W (RATEBITS)
    ) u_rate_cnt (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .clr_i   (start_gate),
        .inc_i   (cnt_inc),
        .cnt_o   (cnt)
    );

    // One extra bit so goal+deadband and count+deadband cannot wrap.
    assign hi_lim = {1'b0, goal_i} + {1'b0, deadband_i};
    assign lo_sum = {1'b0, cnt} + {1'b0, deadband_i};

    always_comb begin
        next_calc = thr_q;
        if ({1'b0, cnt} > hi_lim) begin
            next_calc = TW'(sat_add(32'(thr_q), 32'(step_i), THR_MAX));
        end else if (lo_sum < {1'b0, goal_i}) begin
            next_calc = TW'(sat_sub(32'(thr_q), 32'(step_i)));
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q    <= ST_IDLE;
            period_q   <= PERIODBITS'(1);
            gate_cnt_q <= '0;
            thr_q      <= TW'(THRESH_DEFAULT);
            next_q     <= TW'(THRESH_DEFAULT);
            thr_upd_q  <= 1'b0;
            rate_q     <= '0;
            rate_vld_q <= 1'b0;
        end else begin
            thr_upd_q  <= 1'b0;
            rate_vld_q <= 1'b0;
            if (load_i) begin
                thr_q     <= threshold_init_i;
                thr_upd_q <= (threshold_init_i != thr_q);
                state_q   <= enable_i ? ST_COUNT : ST_IDLE;
            end else if (!enable_i) begin
                state_q <= ST_IDLE;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        state_q <= ST_COUNT;
                    end
                    ST_COUNT: begin
                        if (gate_cnt_q == period_q - PERIODBITS'(1)) begin
                            state_q <= ST_EVAL;
                        end else begin
                            gate_cnt_q <= gate_cnt_q + PERIODBITS'(1);
                        end
                    end
                    ST_EVAL: begin
                        rate_q     <= cnt;
                        rate_vld_q <= 1'b1;
                        next_q     <= next_calc;
                        state_q    <= ST_UPDATE;
                    end
                    ST_UPDATE: begin
                        thr_q     <= next_q;
                        thr_upd_q <= (next_q != thr_q);
                        state_q   <= ST_COUNT;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
            // Gate start overrides the COUNT increment above.
            if (start_gate) begin
                period_q   <= period_lat;
                gate_cnt_q <= '0;
            end
        end
    end

    assign threshold_o        = thr_q;
    assign threshold_update_o = thr_upd_q;
    assign rate_o             = rate_q;
    assign rate_valid_o       = rate_vld_q;

endmodule
